// File: rtl/disp_entry_buffer.sv
// disp_entry_buffer
// Calculator-style digit entry buffer feeding NDIG seven-segment displays.
// Keypad digits shift in from the right (digit 0 = rightmost). Other keys give
// backspace, clear and sign toggle. A separate positional write path lets the
// result path overwrite single digits.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high
//   key_valid  1-cycle strobe qualifying key_code
//   key_code   0-9 digit, 10 backspace, 11 clear, 12 sign toggle, 13-15 ignored
//   wr_valid   1-cycle strobe for a positional write (loses to key_valid)
//   wr_pos     target digit index of the positional write
//   wr_dig     BCD value of the positional write
//   seg        per-digit segments, bit0=a..bit6=g, active-high, registered
//   count      number of significant digits held
//   neg        sign flag
//   full       count == NDIG
//   err        1-cycle pulse on a rejected key
module disp_entry_buffer #(
  parameter int NDIG = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          key_valid,
  input  logic [3:0]                    key_code,
  input  logic                          wr_valid,
  input  logic [$clog2(NDIG)-1:0]       wr_pos,
  input  logic [3:0]                    wr_dig,
  output logic [NDIG-1:0][6:0]          seg,
  output logic [$clog2(NDIG+1)-1:0]     count,
  output logic                          neg,
  output logic                          full,
  output logic                          err
);

  localparam int CW = $clog2(NDIG + 1);
  localparam logic [NDIG*7-1:0] SEG_RST = {{((NDIG - 1) * 7){1'b0}}, 7'h3F};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [NDIG-1:0][3:0]   dig_r, dig_nxt_s;
  logic [CW-1:0]          count_r, count_nxt_s;
  logic                   neg_r, neg_nxt_s;
  logic                   err_r, err_nxt_s;
  logic                   full_r;
  logic [NDIG-1:0][6:0]   seg_r, seg_nxt_s;
  logic                   wr_ok_s;
  logic [CW-1:0]          wr_cnt_s;

  // BCD digit to seven-segment pattern (a = bit 0)
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Qualify the positional write and compute the count it implies
  always_comb begin
    wr_ok_s  = (32'(wr_pos) < 32'(NDIG)) && (wr_dig < 4'd10);
    wr_cnt_s = CW'(wr_pos) + CW'(1);
  end

  // Next-state decode for keys and positional writes; keys take priority
  always_comb begin
    dig_nxt_s   = dig_r;
    count_nxt_s = count_r;
    neg_nxt_s   = neg_r;
    err_nxt_s   = 1'b0;
    if (key_valid) begin
      case (key_code)
        4'd10: begin
          if (state_r == ST_EMPTY) begin
            err_nxt_s = 1'b1;
          end else begin
            dig_nxt_s   = {4'd0, dig_r[NDIG-1:1]};
            count_nxt_s = count_r - CW'(1);
            // An empty buffer never carries a sign
            if (count_r == CW'(1)) neg_nxt_s = 1'b0;
            else                   neg_nxt_s = neg_r;
          end
        end
        4'd11: begin
          dig_nxt_s   = '0;
          count_nxt_s = '0;
          neg_nxt_s   = 1'b0;
        end
        4'd12: begin
          if (state_r == ST_ENTRY) neg_nxt_s = ~neg_r;
          else                     err_nxt_s = 1'b1;
        end
        4'd13, 4'd14, 4'd15: begin
          err_nxt_s = 1'b0;
        end
        default: begin
          case (state_r)
            ST_EMPTY: begin
              // Leading zeros are swallowed silently
              if (key_code != 4'd0) begin
                dig_nxt_s[0] = key_code;
                count_nxt_s  = CW'(1);
              end else begin
                count_nxt_s  = count_r;
              end
            end
            ST_ENTRY: begin
              dig_nxt_s   = {dig_r[NDIG-2:0], key_code};
              count_nxt_s = count_r + CW'(1);
            end
            ST_FULL: begin
              err_nxt_s = 1'b1;
            end
            default: begin
              err_nxt_s = 1'b0;
            end
          endcase
        end
      endcase
    end else if (wr_valid && wr_ok_s) begin
      dig_nxt_s[wr_pos] = wr_dig;
      if (wr_cnt_s > count_r) count_nxt_s = wr_cnt_s;
      else                    count_nxt_s = count_r;
    end else begin
      err_nxt_s = 1'b0;
    end
  end

  // FSM state follows the new digit count
  always_comb begin
    if (count_nxt_s == '0)              state_nxt_s = ST_EMPTY;
    else if (count_nxt_s == CW'(NDIG))  state_nxt_s = ST_FULL;
    else                                state_nxt_s = ST_ENTRY;
  end

  // Display image of the currently held state (registered one edge later)
  always_comb begin
    seg_nxt_s = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (count_r == '0 && i == 0)             seg_nxt_s[i] = 7'h3F;
      else if (i < int'(count_r))              seg_nxt_s[i] = seg7(dig_r[i]);
      else if (neg_r && i == int'(count_r))    seg_nxt_s[i] = 7'h40;
      else                                     seg_nxt_s[i] = 7'h00;
    end
  end

  // Entry FSM, digit store and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_EMPTY;
      dig_r   <= '0;
      count_r <= '0;
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
      full_r  <= 1'b0;
      seg_r   <= SEG_RST;
    end else begin
      state_r <= state_nxt_s;
      dig_r   <= dig_nxt_s;
      count_r <= count_nxt_s;
      neg_r   <= neg_nxt_s;
      err_r   <= err_nxt_s;
      full_r  <= (state_nxt_s == ST_FULL);
      seg_r   <= seg_nxt_s;
    end
  end

  assign seg   = seg_r;
  assign count = count_r;
  assign neg   = neg_r;
  assign full  = full_r;
  assign err   = err_r;

endmodule

// File: tb/tb_disp_entry_buffer.sv
module tb_disp_entry_buffer;

  localparam int NDIG = 8;
  localparam int PW   = $clog2(NDIG);
  localparam int CW   = $clog2(NDIG + 1);

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      key_valid = 1'b0;
  logic [3:0]                key_code = 4'd0;
  logic                      wr_valid = 1'b0;
  logic [PW-1:0]             wr_pos = '0;
  logic [3:0]                wr_dig = 4'd0;
  logic [NDIG-1:0][6:0]      seg;
  logic [CW-1:0]             count;
  logic                      neg, full, err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: list of digits, significant count, sign, last error pulse
  int  m_dig[NDIG];
  int  m_cnt;
  bit  m_neg;
  bit  m_err;
  logic [NDIG-1:0][6:0]  exp_seg;
  logic [CW+2:0]         exp_stat;

  disp_entry_buffer #(.NDIG(NDIG)) dut (
    .clock(clock), .reset(reset),
    .key_valid(key_valid), .key_code(key_code),
    .wr_valid(wr_valid), .wr_pos(wr_pos), .wr_dig(wr_dig),
    .seg(seg), .count(count), .neg(neg), .full(full), .err(err)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] pat(input int d);
    logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return t[d];
  endfunction

  function automatic logic [NDIG-1:0][6:0] model_seg();
    logic [NDIG-1:0][6:0] s = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (m_cnt == 0 && i == 0)       s[i] = 7'h3F;
      else if (i < m_cnt)             s[i] = pat(m_dig[i]);
      else if (m_neg && i == m_cnt)   s[i] = 7'h40;
      else                            s[i] = 7'h00;
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NDIG; i++) m_dig[i] = 0;
    m_cnt = 0; m_neg = 0; m_err = 0;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit wv, input int wp, input int wd);
    m_err = 0;
    if (kv) begin
      if (kc <= 9) begin
        if (m_cnt == NDIG) m_err = 1;
        else if (!(m_cnt == 0 && kc == 0)) begin
          for (int i = NDIG - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
          m_dig[0] = kc;
          m_cnt++;
        end
      end else if (kc == 10) begin
        if (m_cnt == 0) m_err = 1;
        else begin
          for (int i = 0; i < NDIG - 1; i++) m_dig[i] = m_dig[i+1];
          m_dig[NDIG-1] = 0;
          m_cnt--;
          if (m_cnt == 0) m_neg = 0;
        end
      end else if (kc == 11) begin
        model_clear();
      end else if (kc == 12) begin
        if (m_cnt > 0 && m_cnt < NDIG) m_neg = !m_neg;
        else m_err = 1;
      end
    end else if (wv && wp < NDIG && wd < 10) begin
      m_dig[wp] = wd;
      if (wp + 1 > m_cnt) m_cnt = wp + 1;
    end
  endtask

  // One clock of stimulus; leaves expected status/segments for the caller to compare
  task automatic apply(input bit kv, input int kc, input bit wv, input int wp, input int wd);
    @(negedge clock);
    key_valid = kv; key_code = 4'(kc);
    wr_valid  = wv; wr_pos = PW'(wp); wr_dig = 4'(wd);
    exp_seg = model_seg();
    model_step(kv, kc, wv, wp, wd);
    exp_stat = {CW'(m_cnt), m_neg, (m_cnt == NDIG), m_err};
    @(posedge clock);
    #2;
    key_valid = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    #12;
    vectors++;
    if ({count, neg, full, err} !== {CW'(0), 3'b000})
      begin $display("FAIL reset_status got %h exp %h", {count, neg, full, err}, {CW'(0), 3'b000}); miscompares++; end
    vectors++;
    if (seg !== {{(NDIG-1)*7{1'b0}}, 7'h3F})
      begin $display("FAIL reset_seg got %h exp %h", seg, {{(NDIG-1)*7{1'b0}}, 7'h3F}); miscompares++; end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_digits();
    apply(1, 1, 0, 0, 0);
    apply(1, 2, 0, 0, 0);
    apply(1, 3, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if ({count, neg, full, err} !== exp_stat) begin $display("FAIL digits_status got %h exp %h", {count, neg, full, err}, exp_stat); miscompares++; end
    vectors++;
    if (seg !== exp_seg) begin $display("FAIL digits_seg got %h exp %h", seg, exp_seg); miscompares++; end
    vectors++;
    if (count !== CW'(3) || seg[2:0] !== {7'h06, 7'h5B, 7'h4F} || seg[NDIG-1:3] !== '0)
      begin $display("FAIL digits_123 got count %0d seg %h exp count 3 seg[2:0] 065b4f", count, seg); miscompares++; end
  endtask

  task automatic test_leading_zero();
    int errs = 0;
    apply(1, 11, 0, 0, 0);
    apply(1, 0, 0, 0, 0);  errs += int'(err);
    apply(1, 0, 0, 0, 0);  errs += int'(err);
    apply(1, 5, 0, 0, 0);  errs += int'(err);
    apply(0, 0, 0, 0, 0);  errs += int'(err);
    vectors++;
    if (errs !== 0) begin $display("FAIL lz_err got %0d err pulses exp 0", errs); miscompares++; end
    vectors++;
    if (count !== CW'(1) || seg[0] !== 7'h6D || seg !== exp_seg)
      begin $display("FAIL lz_value got count %0d seg %h exp count 1 seg %h", count, seg, exp_seg); miscompares++; end
  endtask

  task automatic test_full();
    apply(1, 11, 0, 0, 0);
    for (int i = 0; i < NDIG; i++) apply(1, 9, 0, 0, 0);
    vectors++;
    if (full !== 1'b1 || count !== CW'(NDIG)) begin $display("FAIL full_flag got full %b count %0d exp 1 %0d", full, count, NDIG); miscompares++; end
    apply(1, 4, 0, 0, 0);
    vectors++;
    if ({count, neg, full, err} !== exp_stat || err !== 1'b1)
      begin $display("FAIL full_err got %h exp %h", {count, neg, full, err}, exp_stat); miscompares++; end
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (err !== 1'b0 || seg !== {NDIG{7'h6F}})
      begin $display("FAIL full_hold got err %b seg %h exp err 0 seg %h", err, seg, {NDIG{7'h6F}}); miscompares++; end
  endtask

  task automatic test_sign();
    apply(1, 11, 0, 0, 0);
    apply(1, 7, 0, 0, 0);
    apply(1, 8, 0, 0, 0);
    apply(1, 12, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (neg !== 1'b1 || seg[2] !== 7'h40 || seg !== exp_seg)
      begin $display("FAIL sign_minus got neg %b seg %h exp neg 1 seg %h", neg, seg, exp_seg); miscompares++; end
    apply(1, 10, 0, 0, 0);
    apply(1, 10, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (count !== CW'(0) || neg !== 1'b0 || seg !== {{(NDIG-1)*7{1'b0}}, 7'h3F})
      begin $display("FAIL sign_bs got count %0d neg %b seg %h exp 0 0 %h", count, neg, seg, exp_seg); miscompares++; end
    apply(1, 12, 0, 0, 0);
    vectors++;
    if (err !== 1'b1 || neg !== 1'b0) begin $display("FAIL sign_empty got err %b neg %b exp 1 0", err, neg); miscompares++; end
  endtask

  task automatic test_write();
    apply(1, 11, 0, 0, 0);
    apply(1, 1, 0, 0, 0);
    apply(1, 2, 0, 0, 0);
    apply(0, 0, 1, 5, 3);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (count !== CW'(6) || seg[5] !== 7'h4F || seg[4:2] !== {3{7'h3F}} || seg !== exp_seg)
      begin $display("FAIL write_pos got count %0d seg %h exp 6 %h", count, seg, exp_seg); miscompares++; end
    apply(0, 0, 1, 5, 11);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if ({count, neg, full, err} !== exp_stat || seg !== exp_seg || seg[5] !== 7'h4F)
      begin $display("FAIL write_drop got %h seg %h exp %h seg %h", {count, neg, full, err}, seg, exp_stat, exp_seg); miscompares++; end
  endtask

  task automatic test_collision();
    apply(1, 11, 0, 0, 0);
    apply(1, 4, 1, 7, 1);
    apply(0, 0, 0, 0, 0);
    vectors++;
    if (count !== CW'(1) || seg !== exp_seg || seg[0] !== 7'h66 || seg[7] !== 7'h00)
      begin $display("FAIL collision got count %0d seg %h exp 1 %h", count, seg, exp_seg); miscompares++; end
  endtask

  task automatic test_async_reset();
    apply(1, 3, 0, 0, 0);
    apply(1, 12, 0, 0, 0);
    apply(0, 0, 0, 0, 0);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({count, neg, full, err} !== {CW'(0), 3'b000} || seg !== {{(NDIG-1)*7{1'b0}}, 7'h3F})
      begin $display("FAIL async_reset got %h seg %h exp 0 seg 3f", {count, neg, full, err}, seg); miscompares++; end
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    int kc, wp, wd;
    bit kv, wv;
    for (int n = 0; n < 400; n++) begin
      kv = ($urandom_range(0, 99) < 60);
      kc = ($urandom_range(0, 99) < 65) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      wv = ($urandom_range(0, 99) < 30);
      wp = $urandom_range(0, NDIG - 1);
      wd = ($urandom_range(0, 99) < 80) ? $urandom_range(0, 9) : $urandom_range(10, 15);
      apply(kv, kc, wv, wp, wd);
      vectors++;
      if ({count, neg, full, err} !== exp_stat)
        begin $display("FAIL rand_status step %0d got %h exp %h", n, {count, neg, full, err}, exp_stat); miscompares++; end
      vectors++;
      if (seg !== exp_seg)
        begin $display("FAIL rand_seg step %0d got %h exp %h", n, seg, exp_seg); miscompares++; end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_digits();
    test_leading_zero();
    test_full();
    test_sign();
    test_write();
    test_collision();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
